line_scan_winner: RTL and testbench
===================================

// Module: line_scan_winner
// PURPOSE
//  Parametrised, sequential tic-tac-toe winner detector for an N x N board (N-in-a-row).
//  - On a start pulse, snapshots the board and scans one line per clock.
//  - Scan order: rows, then columns, then the two diagonals.
//  - Reports winner, winning line index, draw and illegal-board (conflict).
//  - Sits between the board register file and the game-control FSM.
//  - Replaces the per-line combinational detectors.
// PARAMETERS
//  N     3                      board dimension; win requires N equal marks in a line; N >= 3
//  LINES 2*N+2 (localparam)     number of lines scanned
//  LW    $clog2(2*N+2) (local)  width of line index
// PORTS
//  clk       input   1      system clock, rising edge
//  rst_n     input   1      asynchronous active-low reset
//  start     input   1      request evaluation; sampled only in IDLE
//  board     input   2*N*N  cell k = board[2k+1:2k], k = r*N+c; 00 empty, 01 X, 10 O, 11 treated as empty
//  busy      output  1      high from cycle after accepted start until done cycle inclusive
//  done      output  1      one-cycle pulse: result outputs valid from this cycle
//  win       output  1      at least one line holds N identical non-empty marks
//  who       output  2      player of first winning line in scan order; 00 if no win
//  win_line  output  LW     index of first winning line; 0 if no win
//  draw      output  1      all N*N cells non-empty and win==0
//  conflict  output  1      winning lines exist for both X and O (illegal board)
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE, line counter 0, snapshot 0.
//    All outputs (busy, done, win, who, win_line, draw, conflict) = 0.
//  - States and transitions:
//    - IDLE: if start, latch board into snapshot; clear result regs; idx <= 0; go to SCAN.
//    - SCAN: evaluate line idx on the snapshot; idx <= idx+1.
//      After evaluating idx == LINES-1, go to DONE.
//    - DONE: done=1 for exactly this cycle; draw computed from snapshot; return to IDLE.
//  - Line numbering:
//    - 0..N-1: rows r (cells r*N+0..r*N+N-1).
//    - N..2N-1: columns c = idx-N (cells c, c+N, ..).
//    - 2N: main diagonal (cells k*(N+1)).
//    - 2N+1: anti-diagonal (cells (k+1)*(N-1), k = 0..N-1).
//  - Line match: all N cells equal, value 01 or 10. 11 and 00 never match.
//  - First match: win<=1, who<=mark, win_line<=idx. Later matches do not overwrite.
//  - Later match with a different mark sets conflict<=1 (sticky until next start).
//  - Latency: start sampled at edge T.
//    - SCAN occupies edges T+1 .. T+LINES.
//    - done high in the cycle after edge T+LINES+1; for N=3: 9 cycles after the start edge.
//    - Fixed latency, no early exit.
//  - Board input may change freely after the start edge; only the snapshot is used.
//  - win/who/win_line/draw/conflict hold their values after done until the next accepted start.
//    They clear on that start edge.
//  - start while busy (SCAN or DONE) is ignored and does not queue.
//  - start held high continuously: a new scan is accepted on each return to IDLE.
//  - rst_n asserted mid-scan: immediate return to IDLE, all outputs 0, no done pulse.
//  - draw and win are mutually exclusive. Full board with a winning line: draw=0.
// TESTING
//  1. N=3, board all 00, start -> done exactly 9 cycles after start edge; win=0 who=00 draw=0 conflict=0.
//  2. N=3, cells 6,7,8 = 01 (bottom row X), rest 00 -> win=1 who=01 win_line=2.
//     Also cells 2,4,6 = 10 (anti-diag O), rest 00 -> win=1 who=10 win_line=7.
//  3. N=3, full board X O X / X O O / O X X -> win=0 draw=1.
//     Same board with cell 8 = 11 -> draw=0 win=0.
//  4. N=3, row0 all 01 and row1 all 10 -> win=1 who=01 win_line=0 conflict=1.
//     Next start with empty board -> conflict=0.
//  5. Start pulse during SCAN -> ignored, single done pulse.
//     Change board after start edge -> result reflects snapshot.
//     rst_n low mid-scan -> busy=0, no done, outputs 0.
//  6. N=4, column 3 all 10 (cells 3,7,11,15) -> done 11 cycles after start, win=1 who=10 win_line=7.
//     N=4, row 3 with only 3 X -> win=0.

Source files
------------

// File: rtl/line_scan_winner.sv
// Sequential N-in-a-row winner detector: snapshots the board on start and
// evaluates one line per clock (rows, columns, main diagonal, anti-diagonal).
module line_scan_winner #(
    parameter  int N     = 3,
    localparam int LINES = 2*N + 2,
    localparam int LW    = $clog2(LINES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2*N*N-1:0]  board,
    output logic              busy,
    output logic              done,
    output logic              win,
    output logic [1:0]        who,
    output logic [LW-1:0]     win_line,
    output logic              draw,
    output logic              conflict
);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

    localparam logic [1:0] MARK_X = 2'b01;
    localparam logic [1:0] MARK_O = 2'b10;

    state_t           state_q, state_d;
    logic [LW-1:0]    idx_q, idx_d;
    logic [2*N*N-1:0] snap_q, snap_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             win_q, win_d;
    logic [1:0]       who_q, who_d;
    logic [LW-1:0]    win_line_q, win_line_d;
    logic             draw_q, draw_d;
    logic             conflict_q, conflict_d;

    logic [1:0]       line_mark;
    logic             line_hit;
    logic [1:0]       cell_v;
    logic             board_full;

    // Cell number of the k-th cell along line ln.
    function automatic int line_cell(input int ln, input int k);
        if (ln < N)           return ln*N + k;
        else if (ln < 2*N)    return (ln - N) + k*N;
        else if (ln == 2*N)   return k*(N + 1);
        else                  return (k + 1)*(N - 1);
    endfunction

    // NOTE: every signal written in always_comb gets a default first, so no latches are inferred.
    always_comb begin
        line_mark = 2'(snap_q >> (2*line_cell(int'(idx_q), 0)));
        line_hit  = (line_mark == MARK_X) || (line_mark == MARK_O);
        for (int k = 1; k < N; k++) begin
            if (2'(snap_q >> (2*line_cell(int'(idx_q), k))) != line_mark)
                line_hit = 1'b0;
        end
    end

    // Code 11 counts as empty, so it keeps the board from being full.
    always_comb begin
        cell_v     = 2'b00;
        board_full = 1'b1;
        for (int k = 0; k < N*N; k++) begin
            cell_v = 2'(snap_q >> (2*k));
            if ((cell_v != MARK_X) && (cell_v != MARK_O))
                board_full = 1'b0;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        snap_d     = snap_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        win_d      = win_q;
        who_d      = who_q;
        win_line_d = win_line_q;
        draw_d     = draw_q;
        conflict_d = conflict_q;

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    snap_d     = board;
                    idx_d      = '0;
                    busy_d     = 1'b1;
                    win_d      = 1'b0;
                    who_d      = 2'b00;
                    win_line_d = '0;
                    draw_d     = 1'b0;
                    conflict_d = 1'b0;
                    state_d    = S_SCAN;
                end
            end
            S_SCAN: begin
                if (line_hit) begin
                    if (!win_q) begin
                        win_d      = 1'b1;
                        who_d      = line_mark;
                        win_line_d = idx_q;
                    end else if (line_mark != who_q) begin
                        conflict_d = 1'b1;
                    end
                end
                idx_d = idx_q + 1'b1;
                if (idx_q == LW'(LINES - 1))
                    state_d = S_DONE;
            end
            S_DONE: begin
                done_d  = 1'b1;
                draw_d  = board_full && !win_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    // NOTE: the snapshot is reset along with the control state so results never depend on power-up contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            snap_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            win_q      <= 1'b0;
            who_q      <= 2'b00;
            win_line_q <= '0;
            draw_q     <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            snap_q     <= snap_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            win_q      <= win_d;
            who_q      <= who_d;
            win_line_q <= win_line_d;
            draw_q     <= draw_d;
            conflict_q <= conflict_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign win      = win_q;
    assign who      = who_q;
    assign win_line = win_line_q;
    assign draw     = draw_q;
    assign conflict = conflict_q;

endmodule

// File: tb/tb_line_scan_winner.sv
// Self-checking bench for line_scan_winner with N=3 and N=4 instances:
// directed vector table, multi-cycle corner sequences and random boards.
module tb_line_scan_winner;

    typedef struct packed {
        logic       win;
        logic [1:0] who;
        logic [3:0] line;
        logic       draw;
        logic       conflict;
    } res_t;

    typedef struct {
        int          n;
        logic [31:0] board;
        res_t        exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start3, start4;
    logic [17:0] board3;
    logic [31:0] board4;
    logic        busy3, done3, win3, draw3, conf3;
    logic        busy4, done4, win4, draw4, conf4;
    logic [1:0]  who3, who4;
    logic [2:0]  line3;
    logic [3:0]  line4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    line_scan_winner #(.N(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .board(board3),
        .busy(busy3), .done(done3), .win(win3), .who(who3),
        .win_line(line3), .draw(draw3), .conflict(conf3)
    );

    line_scan_winner #(.N(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .board(board4),
        .busy(busy4), .done(done4), .win(win4), .who(who4),
        .win_line(line4), .draw(draw4), .conflict(conf4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Board from text: '.' empty, 'X', 'O', '#' = code 11; cell 0 first, spaces ignored.
    function automatic logic [31:0] brd(input string s);
        logic [31:0] b = '0;
        int k = 0;
        for (int i = 0; i < s.len(); i++) begin
            if (s[i] != " ") begin
                if (s[i] == "X")      b |= 32'h1 << (2*k);
                else if (s[i] == "O") b |= 32'h2 << (2*k);
                else if (s[i] == "#") b |= 32'h3 << (2*k);
                k++;
            end
        end
        return b;
    endfunction

    // Cell number of the k-th cell of line ln, from row/column geometry.
    function automatic int cell_of(input int n, input int ln, input int k);
        int r, c;
        if (ln < n)           begin r = ln; c = k;         end
        else if (ln < 2*n)    begin r = k;  c = ln - n;    end
        else if (ln == 2*n)   begin r = k;  c = k;         end
        else                  begin r = k;  c = n - 1 - k; end
        return r*n + c;
    endfunction

    function automatic res_t model(input int n, input logic [31:0] b);
        res_t r = '0;
        bit has_x = 0, has_o = 0, full = 1;
        for (int ln = 0; ln < 2*n + 2; ln++) begin
            logic [1:0] first = 2'(b >> (2*cell_of(n, ln, 0)));
            bit same = (first == 2'b01) || (first == 2'b10);
            for (int k = 1; k < n; k++)
                if (2'(b >> (2*cell_of(n, ln, k))) != first) same = 0;
            if (same) begin
                if (first == 2'b01) has_x = 1; else has_o = 1;
                if (!r.win) begin
                    r.win  = 1'b1;
                    r.who  = first;
                    r.line = 4'(ln);
                end
            end
        end
        for (int k = 0; k < n*n; k++) begin
            logic [1:0] m = 2'(b >> (2*k));
            if (m == 2'b00 || m == 2'b11) full = 0;
        end
        r.conflict = has_x && has_o;
        r.draw     = full && !r.win;
        return r;
    endfunction

    function automatic logic [31:0] rand_board(input int n);
        logic [31:0] b = '0;
        for (int k = 0; k < n*n; k++) begin
            int v = $urandom_range(0, 9);
            logic [1:0] m = (v < 3) ? 2'b00 : (v < 6) ? 2'b01 : (v < 9) ? 2'b10 : 2'b11;
            b |= 32'(m) << (2*k);
        end
        if ($urandom_range(0, 2) == 0) begin
            int ln = $urandom_range(0, 2*n + 1);
            logic [1:0] m = 2'($urandom_range(1, 2));
            for (int k = 0; k < n; k++) begin
                int c = cell_of(n, ln, k);
                b = (b & ~(32'h3 << (2*c))) | (32'(m) << (2*c));
            end
        end
        return b;
    endfunction

    task automatic drive(input int n, input logic [31:0] b, input logic s);
        if (n == 3) begin board3 = b[17:0]; start3 = s; end
        else        begin board4 = b;       start4 = s; end
    endtask

    function automatic logic get_done(input int n);
        return (n == 3) ? done3 : done4;
    endfunction

    function automatic logic get_busy(input int n);
        return (n == 3) ? busy3 : busy4;
    endfunction

    function automatic res_t get_res(input int n);
        res_t r;
        if (n == 3) begin
            r.win = win3; r.who = who3; r.line = {1'b0, line3}; r.draw = draw3; r.conflict = conf3;
        end else begin
            r.win = win4; r.who = who4; r.line = line4; r.draw = draw4; r.conflict = conf4;
        end
        return r;
    endfunction

    task automatic check_res(input string tag, input res_t got, input res_t exp);
        check({tag, ".win"},      32'(got.win),      32'(exp.win));
        check({tag, ".who"},      32'(got.who),      32'(exp.who));
        check({tag, ".win_line"}, 32'(got.line),     32'(exp.line));
        check({tag, ".draw"},     32'(got.draw),     32'(exp.draw));
        check({tag, ".conflict"}, 32'(got.conflict), 32'(exp.conflict));
    endtask

    // One accepted start, input board scrambled after the start edge, full result and timing checks.
    task automatic run_scan(input string tag, input int n, input logic [31:0] b, input res_t exp);
        int lat;
        @(negedge clk);
        drive(n, b, 1'b1);
        @(negedge clk);
        drive(n, $urandom, 1'b0);
        check({tag, ".busy_after_start"}, 32'(get_busy(n)), 1);
        lat = 0;
        while (!get_done(n) && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, ".latency"}, lat, 2*n + 3);
        check({tag, ".busy_in_done"}, 32'(get_busy(n)), 1);
        check_res(tag, get_res(n), exp);
        @(negedge clk);
        check({tag, ".done_one_cycle"}, 32'(get_done(n)), 0);
        check({tag, ".busy_cleared"}, 32'(get_busy(n)), 0);
        repeat (2) @(negedge clk);
        check_res({tag, ".hold"}, get_res(n), exp);
    endtask

    vec_t vecs[13];

    initial begin
        int pulses;
        res_t r_seen;

        vecs[0]  = '{3, brd("... ... ..."), '{1'b0, 2'b00, 4'd0, 1'b0, 1'b0}};
        vecs[1]  = '{3, brd("... ... XXX"), '{1'b1, 2'b01, 4'd2, 1'b0, 1'b0}};
        vecs[2]  = '{3, brd("..O .O. O.."), '{1'b1, 2'b10, 4'd7, 1'b0, 1'b0}};
        vecs[3]  = '{3, brd("XOX XOO OXX"), '{1'b0, 2'b00, 4'd0, 1'b1, 1'b0}};
        vecs[4]  = '{3, brd("XOX XOO OX#"), '{1'b0, 2'b00, 4'd0, 1'b0, 1'b0}};
        vecs[5]  = '{3, brd("XXX OOO ..."), '{1'b1, 2'b01, 4'd0, 1'b0, 1'b1}};
        vecs[6]  = '{3, brd("... ... ..."), '{1'b0, 2'b00, 4'd0, 1'b0, 1'b0}};
        vecs[7]  = '{3, brd("X.. .X. ..X"), '{1'b1, 2'b01, 4'd6, 1'b0, 1'b0}};
        vecs[8]  = '{3, brd(".O. .O. .O."), '{1'b1, 2'b10, 4'd4, 1'b0, 1'b0}};
        vecs[9]  = '{3, brd("XXX OOX OXO"), '{1'b1, 2'b01, 4'd0, 1'b0, 1'b0}};
        vecs[10] = '{4, brd("...O ...O ...O ...O"), '{1'b1, 2'b10, 4'd7, 1'b0, 1'b0}};
        vecs[11] = '{4, brd(".... .... .... XXX."), '{1'b0, 2'b00, 4'd0, 1'b0, 1'b0}};
        vecs[12] = '{4, brd("...X ..X. .X.. X..."), '{1'b1, 2'b01, 4'd9, 1'b0, 1'b0}};

        rst_n = 1'b0; start3 = 1'b0; start4 = 1'b0; board3 = '0; board4 = '0;
        #12;
        check("reset.n3", {busy3, done3, win3, who3, line3, draw3, conf3}, 0);
        check("reset.n4", {busy4, done4, win4, who4, line4, draw4, conf4}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++)
            run_scan($sformatf("vec%0d", i), vecs[i].n, vecs[i].board, vecs[i].exp);

        // Start pulse during SCAN must be ignored: one done, result from the first snapshot.
        @(negedge clk);
        board3 = brd("... ... ..."); start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0; board3 = brd("XXX ... ...");
        repeat (2) @(negedge clk);
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        pulses = 0; r_seen = '0;
        repeat (20) begin
            @(negedge clk);
            if (done3) begin pulses++; r_seen = get_res(3); end
        end
        check("ignore.pulses", pulses, 1);
        check("ignore.win", 32'(r_seen.win), 0);

        // Start held high: a new scan is accepted on every return to IDLE.
        @(negedge clk);
        board3 = brd("O.. O.. O.."); start3 = 1'b1;
        pulses = 0;
        repeat (26) begin
            @(negedge clk);
            if (done3) pulses++;
        end
        start3 = 1'b0;
        check("held.pulses", pulses, 2);
        check("held.line", 32'(line3), 3);
        repeat (15) @(negedge clk);

        // Reset in the middle of a scan that has already found a win.
        @(negedge clk);
        board3 = brd("XXX ... ..."); start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset.outputs", {busy3, done3, win3, who3, line3, draw3, conf3}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (done3 || busy3) pulses++;
        end
        check("midreset.no_done", pulses, 0);

        for (int i = 0; i < 40; i++) begin
            int n = (i % 2) ? 4 : 3;
            logic [31:0] b = rand_board(n);
            if (n == 3) b = b & 32'h3FFFF;
            run_scan($sformatf("rand%0d", i), n, b, model(n, b));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
